hazard_resolver: RTL and testbench
==================================

Name: hazard_resolver

Overview:
- Consumer of the decode-stage dependency vector (dep_place) produced by the pipeline dependency checker.
- Turns the vector into operand forwarding selects, forwarded operand values, load-use stalls and branch flush control for the 5-stage RV32I core.
- Sits between the decode/execute pipeline registers and the hazard checker; drives pipeline-register enables and bubble insertion.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush_if_id stays asserted after a taken branch (>=1).
- XLEN, 32, operand data width.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- dep_place  input  4  [0] rs1==rd_ex, [1] rs2==rd_ex, [2] rs1==rd_mem, [3] rs2==rd_mem
- rs1_id  input  5  decode rs1 index (instruction[19:15])
- rs2_id  input  5  decode rs2 index (instruction[24:20])
- opcode_ex  input  7  execute-stage opcode
- opcode_mem  input  7  mem-stage opcode
- branch_taken  input  1  taken branch resolved in EX this cycle
- rs1_rf, rs2_rf  input  XLEN  register-file read data
- ex_result  input  XLEN  ALU output of execute stage
- mem_result  input  XLEN  mem-stage writeback value (load data or passed ALU result)
- op1, op2  output  XLEN  resolved decode operands
- fwd_a, fwd_b  output  2  00 regfile, 01 EX, 10 MEM
- stall_if_id  output  1  hold PC and IF/ID register
- bubble_ex  output  1  insert NOP into ID/EX register
- flush_if_id  output  1  squash IF/ID contents

Behaviour:
- State register (RUN, LOAD_STALL, FLUSH) plus flush counter. Reset: state RUN, counter 0. While rst=1, stall_if_id, bubble_ex, flush_if_id = 0 and fwd_a/fwd_b = 00.
- Qualification: EX bits (0,1) are valid only if writes_rd(opcode_ex); MEM bits (2,3) only if writes_rd(opcode_mem); writes_rd is true for `REG, `IMM, `LOAD. Any bit whose source index is 0 is ignored (x0 never forwarded).
- Forward select (combinational, 0 latency): fwd_a = 01 if qualified bit0, else 10 if qualified bit2, else 00. fwd_b likewise uses bits 1/3. The EX stage (younger) wins when both are set. op1/op2 = mux of rs*_rf / ex_result / mem_result.
- Load-use: in RUN, qualified bit0 or bit1 with opcode_ex==`LOAD -> stall_if_id=1, bubble_ex=1 this cycle; next state LOAD_STALL. In LOAD_STALL the load sits in MEM. The select comes from bits 2/3 (mem_result); no stall. State returns to RUN unconditionally after 1 cycle. A second load-use in the following cycle re-stalls.
- Branch flush: branch_taken=1 in any state -> flush_if_id=1 and bubble_ex=1 the same cycle. Counter loads FLUSH_CYCLES-1 and state goes to FLUSH (or RUN if FLUSH_CYCLES==1). In FLUSH: flush_if_id=1 and counter decrements; exit to RUN when counter reaches 0. branch_taken during FLUSH reloads the counter.
- Priority: flush > load-use stall. When both occur, stall_if_id=0 and the state goes to FLUSH, not LOAD_STALL.
- fwd_* are still computed during FLUSH, but the consumer ignores them.
- Synchronous rst mid-FLUSH or mid-LOAD_STALL: RUN next cycle, counter cleared.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0]. Each is saturating at 0xFFFFFFFF, counts cycles with stall_if_id=1 or flush_if_id=1 respectively, and is cleared by rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package/params.vh holds the opcode constants (`REG, `IMM, `LOAD, `BRANCH), the fwd encodings (FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10), the state encodings, and the writes_rd function.
- One natural sub-module: fwd_mux (per-operand 3:1 select). Instantiate it twice.

Test Plan:
- ADD in EX rd=x5, decode rs1=x5, dep_place=0001, ex_result=0x1234 -> fwd_a=01, op1=0x1234, no stall.
- LW in EX rd=x7, decode rs2=x7, dep_place=0010 -> stall_if_id=1, bubble_ex=1 for 1 cycle. Next cycle dep_place=1000, opcode_mem=`LOAD, mem_result=0xCAFE -> fwd_b=10, op2=0xCAFE, stall=0.
- rs1=x0 with dep_place=0101 and writing opcodes -> fwd_a=00, op1=rs1_rf.
- Store in EX with dep_place=0001 -> fwd_a=00 (store writes no rd).
- Taken branch with FLUSH_CYCLES=2 -> flush_if_id high exactly 2 cycles; branch_taken together with load-use -> stall_if_id=0, flush wins.
- HAZARD_STATS_EN defined: 3 load-use events + 1 branch -> stall_cnt=3, flush_cnt=2; rst clears both to 0.

Source files
------------

// File: rtl/hazard_resolver_pkg.sv
// Shared definitions for the hazard resolver slice.
// Contents: RV32I major opcodes seen by the resolver, forwarding select
// encodings, the control FSM state type and the writes_rd() predicate that
// decides whether an in-flight instruction produces a register result.
package hazard_resolver_pkg;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2
  } state_t;

  // Only register-register, register-immediate and load instructions
  // write rd; stores and branches reuse bits [11:7] for other purposes.
  function automatic logic writes_rd(input logic [6:0] opcode);
    return (opcode == OP_REG) || (opcode == OP_IMM) || (opcode == OP_LOAD);
  endfunction

endpackage

// File: rtl/hazard_resolver_fwd_mux.sv
// Per-operand 3:1 forwarding select.
// Ports:
//   sel      - forwarding select (FWD_RF / FWD_EX / FWD_MEM)
//   rf_data  - register-file read data
//   ex_data  - execute-stage ALU result
//   mem_data - mem-stage writeback value
//   operand  - resolved operand
module hazard_resolver_fwd_mux
  import hazard_resolver_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] rf_data,
  input  logic [XLEN-1:0] ex_data,
  input  logic [XLEN-1:0] mem_data,
  output logic [XLEN-1:0] operand
);

  // The unused encoding 2'b11 falls back to the register file.
  always_comb begin
    operand = rf_data;
    case (sel)
      FWD_EX:  operand = ex_data;
      FWD_MEM: operand = mem_data;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_resolver.sv
// Decode-stage hazard resolver for the 5-stage RV32I core.
// Converts the dependency vector from the hazard checker into operand
// forwarding selects / values, load-use stall + bubble, and branch flush.
// Ports:
//   clk, rst          - core clock, synchronous active-high reset
//   dep_place[3:0]    - [0] rs1==rd_ex [1] rs2==rd_ex [2] rs1==rd_mem [3] rs2==rd_mem
//   rs1_id, rs2_id    - decode source register indices
//   opcode_ex/_mem    - opcodes of the instructions in EX and MEM
//   branch_taken      - taken branch resolved in EX this cycle
//   rs1_rf, rs2_rf    - register-file read data
//   ex_result         - EX ALU result
//   mem_result        - MEM writeback value
//   op1, op2          - resolved decode operands
//   fwd_a, fwd_b      - forwarding selects (00 RF, 01 EX, 10 MEM)
//   stall_if_id       - hold PC and IF/ID
//   bubble_ex         - insert NOP into ID/EX
//   flush_if_id       - squash IF/ID
// Optional build macro HAZARD_STATS_EN adds saturating event counters
//   stall_cnt / flush_cnt (cycles with stall_if_id / flush_if_id high).
module hazard_resolver
  import hazard_resolver_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      dep_place,
  input  logic [4:0]      rs1_id,
  input  logic [4:0]      rs2_id,
  input  logic [6:0]      opcode_ex,
  input  logic [6:0]      opcode_mem,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] rs1_rf,
  input  logic [XLEN-1:0] rs2_rf,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            stall_if_id,
  output logic            bubble_ex,
  output logic            flush_if_id
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic load_use;

  // Qualified dependencies: producer must write rd and x0 never forwards.
  always_comb begin
    ex_hit_a  = dep_place[0] && writes_rd(opcode_ex)  && (rs1_id != 5'd0);
    ex_hit_b  = dep_place[1] && writes_rd(opcode_ex)  && (rs2_id != 5'd0);
    mem_hit_a = dep_place[2] && writes_rd(opcode_mem) && (rs1_id != 5'd0);
    mem_hit_b = dep_place[3] && writes_rd(opcode_mem) && (rs2_id != 5'd0);
    load_use  = (state_q == ST_RUN) && (opcode_ex == OP_LOAD) && (ex_hit_a || ex_hit_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A taken branch overrides everything, including a concurrent load-use.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (branch_taken) begin
      cnt_d   = CNT_LOAD;
      state_d = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load_use) state_d = ST_LOAD_STALL;
        end
        ST_LOAD_STALL: state_d = ST_RUN;
        ST_FLUSH: begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
          if (cnt_q <= CNT_ONE) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // EX (younger producer) takes precedence over MEM.
  always_comb begin
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    if (!rst) begin
      if (ex_hit_a)       fwd_a = FWD_EX;
      else if (mem_hit_a) fwd_a = FWD_MEM;
      if (ex_hit_b)       fwd_b = FWD_EX;
      else if (mem_hit_b) fwd_b = FWD_MEM;
      flush_if_id = branch_taken || (state_q == ST_FLUSH);
      bubble_ex   = branch_taken || load_use;
      stall_if_id = load_use && !branch_taken;
    end
  end

  hazard_resolver_fwd_mux #(.XLEN(XLEN)) u_mux_a (
    .sel      (fwd_a),
    .rf_data  (rs1_rf),
    .ex_data  (ex_result),
    .mem_data (mem_result),
    .operand  (op1)
  );

  hazard_resolver_fwd_mux #(.XLEN(XLEN)) u_mux_b (
    .sel      (fwd_b),
    .rf_data  (rs2_rf),
    .ex_data  (ex_result),
    .mem_data (mem_result),
    .operand  (op2)
  );

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_if_id && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (flush_if_id && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_resolver.sv
// Testbench for hazard_resolver: directed steps followed by randomized
// traffic, all checked against a register-index level reference model.
module tb_hazard_resolver;

  localparam int FLUSH_CYCLES = 2;
  localparam int XLEN = 32;

  localparam logic [6:0] M_REG    = 7'b0110011;
  localparam logic [6:0] M_IMM    = 7'b0010011;
  localparam logic [6:0] M_LOAD   = 7'b0000011;
  localparam logic [6:0] M_STORE  = 7'b0100011;
  localparam logic [6:0] M_BRANCH = 7'b1100011;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      dep_place;
  logic [4:0]      rs1_id, rs2_id;
  logic [6:0]      opcode_ex, opcode_mem;
  logic            branch_taken;
  logic [XLEN-1:0] rs1_rf, rs2_rf, ex_result, mem_result;
  logic [XLEN-1:0] op1, op2;
  logic [1:0]      fwd_a, fwd_b;
  logic            stall_if_id, bubble_ex, flush_if_id;
`ifdef HAZARD_STATS_EN
  logic [31:0]     stall_cnt, flush_cnt;
`endif

  // destination registers of the instructions in EX / MEM (model only)
  logic [4:0] rd_ex_m, rd_mem_m;

  // reference model state
  int   flush_left;
  logic prev_stalled;
  int   m_stall_cnt, m_flush_cnt;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hazard_resolver #(.FLUSH_CYCLES(FLUSH_CYCLES), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .dep_place    (dep_place),
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .opcode_ex    (opcode_ex),
    .opcode_mem   (opcode_mem),
    .branch_taken (branch_taken),
    .rs1_rf       (rs1_rf),
    .rs2_rf       (rs2_rf),
    .ex_result    (ex_result),
    .mem_result   (mem_result),
    .op1          (op1),
    .op2          (op2),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_if_id  (stall_if_id),
    .bubble_ex    (bubble_ex),
    .flush_if_id  (flush_if_id)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic produces_rd(input logic [6:0] op);
    return (op == M_REG) || (op == M_IMM) || (op == M_LOAD);
  endfunction

  task automatic drive(input logic r, input logic [6:0] oex, input logic [6:0] omem,
                       input logic [4:0] rdex, input logic [4:0] rdmem,
                       input logic [4:0] s1, input logic [4:0] s2, input logic br,
                       input logic [31:0] rf1, input logic [31:0] rf2,
                       input logic [31:0] exr, input logic [31:0] memr);
    rst          = r;
    opcode_ex    = oex;
    opcode_mem   = omem;
    rd_ex_m      = rdex;
    rd_mem_m     = rdmem;
    rs1_id       = s1;
    rs2_id       = s2;
    branch_taken = br;
    rs1_rf       = rf1;
    rs2_rf       = rf2;
    ex_result    = exr;
    mem_result   = memr;
    dep_place    = {s2 == rdmem, s1 == rdmem, s2 == rdex, s1 == rdex};
    #1;
  endtask

  // Evaluate the reference model for the current inputs, compare, then
  // advance model state to what it should be after the coming clock edge.
  task automatic check_model();
    logic [1:0]  e_fa, e_fb;
    logic [31:0] e_op1, e_op2;
    logic        e_stall, e_bubble, e_flush, in_run, lu;
    e_fa = 2'b00; e_fb = 2'b00; e_op1 = rs1_rf; e_op2 = rs2_rf;
    e_stall = 1'b0; e_bubble = 1'b0; e_flush = 1'b0;
    if (!rst) begin
      if (rs1_id != 0 && produces_rd(opcode_ex) && rs1_id == rd_ex_m) begin
        e_fa = 2'b01; e_op1 = ex_result;
      end else if (rs1_id != 0 && produces_rd(opcode_mem) && rs1_id == rd_mem_m) begin
        e_fa = 2'b10; e_op1 = mem_result;
      end
      if (rs2_id != 0 && produces_rd(opcode_ex) && rs2_id == rd_ex_m) begin
        e_fb = 2'b01; e_op2 = ex_result;
      end else if (rs2_id != 0 && produces_rd(opcode_mem) && rs2_id == rd_mem_m) begin
        e_fb = 2'b10; e_op2 = mem_result;
      end
      in_run   = (flush_left == 0) && !prev_stalled;
      lu       = in_run && opcode_ex == M_LOAD &&
                 ((rs1_id != 0 && rs1_id == rd_ex_m) || (rs2_id != 0 && rs2_id == rd_ex_m));
      e_flush  = branch_taken || (flush_left > 0);
      e_bubble = branch_taken || lu;
      e_stall  = lu && !branch_taken;
    end
    chk("fwd_a", 32'(fwd_a), 32'(e_fa));
    chk("fwd_b", 32'(fwd_b), 32'(e_fb));
    chk("op1", op1, e_op1);
    chk("op2", op2, e_op2);
    chk("stall_if_id", 32'(stall_if_id), 32'(e_stall));
    chk("bubble_ex", 32'(bubble_ex), 32'(e_bubble));
    chk("flush_if_id", 32'(flush_if_id), 32'(e_flush));
`ifdef HAZARD_STATS_EN
    chk("stall_cnt", stall_cnt, 32'(m_stall_cnt));
    chk("flush_cnt", flush_cnt, 32'(m_flush_cnt));
`endif
    if (rst) begin
      flush_left = 0; prev_stalled = 1'b0;
      m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      if (branch_taken) flush_left = FLUSH_CYCLES - 1;
      else if (flush_left > 0) flush_left--;
      prev_stalled = e_stall;
      m_stall_cnt += int'(e_stall);
      m_flush_cnt += int'(e_flush);
    end
  endtask

  task automatic advance();
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, M_REG, M_REG, 5'd0, 5'd0, 5'd1, 5'd2, 0, 32'h11, 32'h22, 32'h33, 32'h44);
  endtask

  task automatic load_use_step();
    drive(0, M_LOAD, M_REG, 5'd7, 5'd9, 5'd3, 5'd7, 0, 32'h1, 32'h2, 32'h3, 32'h4);
  endtask

  logic [6:0] ops [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ops[0] = M_REG; ops[1] = M_IMM; ops[2] = M_LOAD; ops[3] = M_STORE; ops[4] = M_BRANCH;
    flush_left = 0; prev_stalled = 1'b0; m_stall_cnt = 0; m_flush_cnt = 0;

    // reset held with active hazards on the inputs
    drive(1, M_LOAD, M_REG, 5'd5, 5'd5, 5'd5, 5'd5, 1, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
    check_model();
    chk("rst_stall", 32'(stall_if_id), 32'd0);
    chk("rst_flush", 32'(flush_if_id), 32'd0);
    chk("rst_bubble", 32'(bubble_ex), 32'd0);
    chk("rst_fwd_a", 32'(fwd_a), 32'd0);
    advance();
    drive(1, M_REG, M_REG, 5'd0, 5'd0, 5'd1, 5'd2, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    check_model(); advance();

    // ADD in EX, rd=x5, decode rs1=x5
    drive(0, M_REG, M_IMM, 5'd5, 5'd9, 5'd5, 5'd3, 0, 32'h1111, 32'h2222, 32'h1234, 32'h5678);
    check_model();
    chk("add_fwd_a", 32'(fwd_a), 32'd1);
    chk("add_op1", op1, 32'h1234);
    chk("add_stall", 32'(stall_if_id), 32'd0);
    advance();

    // LW in EX rd=x7, decode rs2=x7 -> stall
    load_use_step();
    check_model();
    chk("lu_stall", 32'(stall_if_id), 32'd1);
    chk("lu_bubble", 32'(bubble_ex), 32'd1);
    advance();
    // load now in MEM
    drive(0, M_IMM, M_LOAD, 5'd0, 5'd7, 5'd3, 5'd7, 0, 32'h1, 32'h2, 32'h3, 32'hCAFE);
    check_model();
    chk("lu_mem_fwd_b", 32'(fwd_b), 32'd2);
    chk("lu_mem_op2", op2, 32'hCAFE);
    chk("lu_mem_stall", 32'(stall_if_id), 32'd0);
    advance();
    // second load-use right after re-stalls
    load_use_step();
    check_model();
    chk("lu_restall", 32'(stall_if_id), 32'd1);
    advance();

    // rs1 = x0 matches both stages
    drive(0, M_REG, M_IMM, 5'd0, 5'd0, 5'd0, 5'd3, 0, 32'hAAAA, 32'hBBBB, 32'hCCCC, 32'hDDDD);
    check_model();
    chk("x0_fwd_a", 32'(fwd_a), 32'd0);
    chk("x0_op1", op1, 32'hAAAA);
    advance();

    // store in EX does not forward
    drive(0, M_STORE, M_BRANCH, 5'd5, 5'd6, 5'd5, 5'd1, 0, 32'h10, 32'h20, 32'h30, 32'h40);
    check_model();
    chk("store_fwd_a", 32'(fwd_a), 32'd0);
    advance();

    // taken branch: flush for exactly FLUSH_CYCLES cycles
    drive(0, M_BRANCH, M_REG, 5'd0, 5'd0, 5'd1, 5'd2, 1, 32'h1, 32'h2, 32'h3, 32'h4);
    check_model();
    chk("br_flush0", 32'(flush_if_id), 32'd1);
    chk("br_bubble0", 32'(bubble_ex), 32'd1);
    advance();
    idle(); check_model();
    chk("br_flush1", 32'(flush_if_id), 32'd1);
    advance();
    idle(); check_model();
    chk("br_flush2", 32'(flush_if_id), 32'd0);
    advance();

    // branch together with load-use: flush wins
    drive(0, M_LOAD, M_REG, 5'd7, 5'd9, 5'd3, 5'd7, 1, 32'h1, 32'h2, 32'h3, 32'h4);
    check_model();
    chk("brlu_stall", 32'(stall_if_id), 32'd0);
    chk("brlu_flush", 32'(flush_if_id), 32'd1);
    advance();
    idle(); check_model();
    chk("brlu_flush1", 32'(flush_if_id), 32'd1);
    chk("brlu_stall1", 32'(stall_if_id), 32'd0);
    advance();

    // reset in the middle of a flush
    drive(0, M_BRANCH, M_REG, 5'd0, 5'd0, 5'd1, 5'd2, 1, 32'h1, 32'h2, 32'h3, 32'h4);
    check_model(); advance();
    drive(1, M_REG, M_REG, 5'd0, 5'd0, 5'd1, 5'd2, 0, 32'h1, 32'h2, 32'h3, 32'h4);
    check_model(); advance();
    idle(); check_model();
    chk("rst_mid_flush", 32'(flush_if_id), 32'd0);
    advance();

`ifdef HAZARD_STATS_EN
    drive(1, M_REG, M_REG, 5'd0, 5'd0, 5'd1, 5'd2, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    check_model(); advance();
    for (int k = 0; k < 3; k++) begin
      load_use_step(); check_model(); advance();
      idle(); check_model(); advance();
    end
    drive(0, M_BRANCH, M_REG, 5'd0, 5'd0, 5'd1, 5'd2, 1, 32'h1, 32'h2, 32'h3, 32'h4);
    check_model(); advance();
    idle(); check_model(); advance();
    idle(); check_model();
    chk("stats_stall_cnt", stall_cnt, 32'd3);
    chk("stats_flush_cnt", flush_cnt, 32'd2);
    advance();
    drive(1, M_REG, M_REG, 5'd0, 5'd0, 5'd1, 5'd2, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    check_model(); advance();
    idle(); check_model();
    chk("stats_stall_clr", stall_cnt, 32'd0);
    chk("stats_flush_clr", flush_cnt, 32'd0);
    advance();
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0),
            ops[$urandom_range(0, 4)], ops[$urandom_range(0, 4)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0),
            $urandom, $urandom, $urandom, $urandom);
      check_model();
      advance();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
